voxel_frame_sequencer: RTL and testbench

Frame-boundary controller between voxel_axil_csr and voxel_framebuffer_top. Holds host camera and flag updates, plus debug voxel writes, in shadow registers and a small FIFO. Applies them to the renderer only in the gap after frame_done, so a frame never renders with mixed state. Also counts frames, measures frame period and runs a frame watchdog.

---
 rtl/voxel_seq_pkg.sv | 45 ++++
 rtl/voxel_seq_fifo.sv | 61 ++++++
 rtl/voxel_frame_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_voxel_frame_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voxel_seq_pkg.sv
// Shared types and field offsets for the voxel frame sequencer.
package voxel_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DRAIN  = 2'd3
  } seq_state_t;

  // Camera word: eight signed 16-bit fields, x in the top slice.
  localparam int CAM_WIDTH     = 128;
  localparam int CAM_X_MSB     = 127;
  localparam int CAM_X_LSB     = 112;
  localparam int CAM_Y_MSB     = 111;
  localparam int CAM_Y_LSB     = 96;
  localparam int CAM_Z_MSB     = 95;
  localparam int CAM_Z_LSB     = 80;
  localparam int CAM_DIRX_MSB  = 79;
  localparam int CAM_DIRX_LSB  = 64;
  localparam int CAM_DIRY_MSB  = 63;
  localparam int CAM_DIRY_LSB  = 48;
  localparam int CAM_DIRZ_MSB  = 47;
  localparam int CAM_DIRZ_LSB  = 32;
  localparam int CAM_PLNX_MSB  = 31;
  localparam int CAM_PLNX_LSB  = 16;
  localparam int CAM_PLNY_MSB  = 15;
  localparam int CAM_PLNY_LSB  = 0;

  // Render flag bit positions.
  localparam int FLAGS_WIDTH       = 4;
  localparam int FLAG_SMOOTH       = 0;
  localparam int FLAG_CURVATURE    = 1;
  localparam int FLAG_EXTRA_LIGHT  = 2;
  localparam int FLAG_DIAG_SLICE   = 3;

  localparam int DBG_ADDR_W = 18;
  localparam int DBG_DATA_W = 64;

  typedef struct packed {
    logic [DBG_ADDR_W-1:0] addr;
    logic [DBG_DATA_W-1:0] data;
  } dbg_entry_t;

endpackage

// File: rtl/voxel_seq_fifo.sv
// Debug voxel-write FIFO: array storage, registered read into pop_data.
module voxel_seq_fifo
  import voxel_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  dbg_entry_t                 push_data,
  input  logic                       pop,
  output dbg_entry_t                 pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  dbg_entry_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  dbg_entry_t      pop_data_reg;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_data = pop_data_reg;

  // Storage write; left unreset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  // Pointers, occupancy and the registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      pop_data_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok) begin
        rd_ptr_reg   <= rd_ptr_reg + AW'(1);
        pop_data_reg <= mem[rd_ptr_reg];
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/voxel_frame_sequencer.sv
// Frame-boundary commit controller for camera, flags and debug voxel writes.
// Optional frame-period measurement is built when VOXEL_SEQ_PERF_EN is defined.
module voxel_frame_sequencer
  import voxel_seq_pkg::*;
#(
  parameter int DBG_FIFO_DEPTH = 8,
  parameter int TIMEOUT_CYCLES = 4194304,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   cam_req,
  input  logic [CAM_WIDTH-1:0]   cam_in,
  input  logic                   flags_req,
  input  logic [FLAGS_WIDTH-1:0] flags_in,
  input  logic                   dbg_req,
  input  logic [17:0]            dbg_addr_in,
  input  logic [63:0]            dbg_data_in,
  output logic                   dbg_full,
  output logic                   dbg_drop,
  input  logic                   frame_done,
  output logic                   cam_load,
  output logic [CAM_WIDTH-1:0]   cam_out,
  output logic                   flags_load,
  output logic [FLAGS_WIDTH-1:0] flags_out,
  output logic                   dbg_we,
  output logic [17:0]            dbg_addr,
  output logic [63:0]            dbg_wdata,
  output logic [CNT_WIDTH-1:0]   frame_count,
  output logic [CNT_WIDTH-1:0]   frame_cycles,
  output logic                   timeout,
  input  logic                   status_clr,
  output logic [1:0]             state
);

  localparam int CW = $clog2(DBG_FIFO_DEPTH) + 1;

  seq_state_t             state_reg, state_next;
  logic [CAM_WIDTH-1:0]   cam_shadow_reg, cam_out_reg;
  logic                   cam_pend_reg;
  logic [FLAGS_WIDTH-1:0] flags_shadow_reg, flags_out_reg;
  logic                   flags_pend_reg;
  logic [CW-1:0]          drain_cnt_reg, drain_cnt_next;
  logic                   redo_reg;
  logic [CNT_WIDTH-1:0]   cyc_cnt_reg, cyc_inc;
  logic [CNT_WIDTH-1:0]   frame_count_reg;
  logic                   timeout_reg, dbg_drop_reg, dbg_we_reg;
  logic                   commit_window, cam_commit, flags_commit;
  logic                   frame_hit, wd_fire, redo_now;
  logic                   fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]          fifo_count;
  dbg_entry_t             fifo_push_data, fifo_pop_data;

  // IDLE passes updates straight through; otherwise only the COMMIT cycle applies them.
  assign commit_window = (state_reg == ST_IDLE) || (state_reg == ST_COMMIT);
  assign cam_commit    = cam_pend_reg && commit_window;
  assign flags_commit  = flags_pend_reg && commit_window;
  assign frame_hit     = frame_done && enable;
  assign wd_fire       = (state_reg == ST_RUN) && enable && !frame_done &&
                         (cyc_cnt_reg == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  assign redo_now      = redo_reg || frame_hit;
  assign cyc_inc       = (cyc_cnt_reg == '1) ? cyc_cnt_reg : cyc_cnt_reg + CNT_WIDTH'(1);

  assign cam_load   = cam_commit;
  assign cam_out    = cam_commit ? cam_shadow_reg : cam_out_reg;
  assign flags_load = flags_commit;
  assign flags_out  = flags_commit ? flags_shadow_reg : flags_out_reg;
  assign dbg_we     = dbg_we_reg;
  assign dbg_addr   = fifo_pop_data.addr;
  assign dbg_wdata  = fifo_pop_data.data;
  assign dbg_full   = fifo_full;
  assign dbg_drop   = dbg_drop_reg;
  assign timeout    = timeout_reg;
  assign frame_count = frame_count_reg;
  assign state      = state_reg;

  assign fifo_push_data.addr = dbg_addr_in;
  assign fifo_push_data.data = dbg_data_in;

  voxel_seq_fifo #(.DEPTH(DBG_FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (dbg_req),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // FSM state register plus the drain bookkeeping it owns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      drain_cnt_reg <= '0;
      redo_reg      <= 1'b0;
      dbg_we_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
      dbg_we_reg    <= fifo_pop && !fifo_empty;
      if (state_next == ST_COMMIT)
        redo_reg <= 1'b0;
      else if (((state_reg == ST_COMMIT) || (state_reg == ST_DRAIN)) && frame_hit)
        redo_reg <= 1'b1;
    end
  end

  // Next-state and FIFO pop decisions; COMMIT pops the first snapshot entry itself.
  always_comb begin
    state_next     = state_reg;
    fifo_pop       = 1'b0;
    drain_cnt_next = drain_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        fifo_pop = !fifo_empty;
        if (enable) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) state_next = ST_IDLE;
        else if (frame_done || wd_fire) state_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (fifo_count != '0) begin
          fifo_pop       = 1'b1;
          drain_cnt_next = fifo_count - CW'(1);
          state_next     = ST_DRAIN;
        end else if (redo_now) begin
          state_next = ST_COMMIT;
        end else begin
          state_next = enable ? ST_RUN : ST_IDLE;
        end
      end
      default: begin
        if (drain_cnt_reg != '0) begin
          fifo_pop       = 1'b1;
          drain_cnt_next = drain_cnt_reg - CW'(1);
        end else if (redo_now) begin
          state_next = ST_COMMIT;
        end else begin
          state_next = enable ? ST_RUN : ST_IDLE;
        end
      end
    endcase
  end

  // Shadow registers: last request wins; a request during commit re-arms pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cam_shadow_reg   <= '0;
      cam_out_reg      <= '0;
      cam_pend_reg     <= 1'b0;
      flags_shadow_reg <= '0;
      flags_out_reg    <= '0;
      flags_pend_reg   <= 1'b0;
    end else begin
      if (cam_commit) cam_out_reg <= cam_shadow_reg;
      if (cam_req) begin
        cam_shadow_reg <= cam_in;
        cam_pend_reg   <= 1'b1;
      end else if (cam_commit) begin
        cam_pend_reg <= 1'b0;
      end
      if (flags_commit) flags_out_reg <= flags_shadow_reg;
      if (flags_req) begin
        flags_shadow_reg <= flags_in;
        flags_pend_reg   <= 1'b1;
      end else if (flags_commit) begin
        flags_pend_reg <= 1'b0;
      end
    end
  end

  // Frame counter, watchdog cycle counter and sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_reg     <= '0;
      frame_count_reg <= '0;
      timeout_reg     <= 1'b0;
      dbg_drop_reg    <= 1'b0;
    end else begin
      if (state_reg == ST_IDLE)    cyc_cnt_reg <= '0;
      else if (frame_hit || wd_fire) cyc_cnt_reg <= '0;
      else                          cyc_cnt_reg <= cyc_inc;
      if (frame_hit) frame_count_reg <= frame_count_reg + CNT_WIDTH'(1);
      if (wd_fire)         timeout_reg <= 1'b1;
      else if (status_clr) timeout_reg <= 1'b0;
      if (dbg_req && fifo_full) dbg_drop_reg <= 1'b1;
      else if (status_clr)      dbg_drop_reg <= 1'b0;
    end
  end

`ifdef VOXEL_SEQ_PERF_EN
  logic [CNT_WIDTH-1:0] frame_cycles_reg;

  // Period between the last two frame_done pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cycles_reg <= '0;
    else if (frame_hit) frame_cycles_reg <= cyc_inc;
  end

  assign frame_cycles = frame_cycles_reg;
`else
  assign frame_cycles = '0;
`endif

endmodule

// File: tb/tb_voxel_frame_sequencer.sv
// Scoreboard bench for voxel_frame_sequencer: expected loads/writes are queued
// with their due cycle when stimulus is driven and popped by a negedge monitor.
module tb_voxel_frame_sequencer;

  localparam int DEPTH = 8;
  localparam int TO    = 128;
  localparam int CW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          cam_req = 1'b0;
  logic [127:0]  cam_in = '0;
  logic          flags_req = 1'b0;
  logic [3:0]    flags_in = '0;
  logic          dbg_req = 1'b0;
  logic [17:0]   dbg_addr_in = '0;
  logic [63:0]   dbg_data_in = '0;
  logic          dbg_full, dbg_drop;
  logic          frame_done = 1'b0;
  logic          cam_load;
  logic [127:0]  cam_out;
  logic          flags_load;
  logic [3:0]    flags_out;
  logic          dbg_we;
  logic [17:0]   dbg_addr;
  logic [63:0]   dbg_wdata;
  logic [CW-1:0] frame_count, frame_cycles;
  logic          timeout;
  logic          status_clr = 1'b0;
  logic [1:0]    state;

  voxel_frame_sequencer #(
    .DBG_FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cam_req(cam_req), .cam_in(cam_in),
    .flags_req(flags_req), .flags_in(flags_in),
    .dbg_req(dbg_req), .dbg_addr_in(dbg_addr_in), .dbg_data_in(dbg_data_in),
    .dbg_full(dbg_full), .dbg_drop(dbg_drop),
    .frame_done(frame_done),
    .cam_load(cam_load), .cam_out(cam_out),
    .flags_load(flags_load), .flags_out(flags_out),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .frame_count(frame_count), .frame_cycles(frame_cycles),
    .timeout(timeout), .status_clr(status_clr), .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [127:0] data;
  } exp_t;

  exp_t cam_q[$];
  exp_t flg_q[$];
  exp_t dbg_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int exp_fc = 0;
  int last_fd = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp_cam(input int c, input logic [127:0] d);
    exp_t e; e.cyc = c; e.data = d; cam_q.push_back(e);
  endtask
  task automatic push_exp_flg(input int c, input logic [3:0] d);
    exp_t e; e.cyc = c; e.data = 128'(d); flg_q.push_back(e);
  endtask
  task automatic push_exp_dbg(input int c, input logic [17:0] a, input logic [63:0] d);
    exp_t e; e.cyc = c; e.data = 128'({a, d}); dbg_q.push_back(e);
  endtask

  task automatic pulse_cam(input logic [127:0] v);
    cam_in = v; cam_req = 1'b1; tick(); cam_req = 1'b0;
  endtask
  task automatic pulse_flags(input logic [3:0] v);
    flags_in = v; flags_req = 1'b1; tick(); flags_req = 1'b0;
  endtask
  task automatic pulse_dbg(input logic [17:0] a, input logic [63:0] d);
    dbg_addr_in = a; dbg_data_in = d; dbg_req = 1'b1; tick(); dbg_req = 1'b0;
  endtask
  task automatic pulse_fd();
    frame_done = 1'b1;
    if (enable) begin exp_fc++; last_fd = cyc; end
    tick();
    frame_done = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: every output pulse must match the head of its queue, data and cycle.
  exp_t mc, mf, md;
  always @(negedge clk) begin
    if (rst_n) begin
      if (cam_load) begin
        if (cam_q.size() == 0) check("cam_unexpected", 128'(1), 128'(0));
        else begin
          mc = cam_q.pop_front();
          check("cam_cyc", 128'(cyc), 128'(mc.cyc));
          check("cam_data", cam_out, mc.data);
        end
      end
      if (flags_load) begin
        if (flg_q.size() == 0) check("flags_unexpected", 128'(1), 128'(0));
        else begin
          mf = flg_q.pop_front();
          check("flags_cyc", 128'(cyc), 128'(mf.cyc));
          check("flags_data", 128'(flags_out), mf.data);
        end
      end
      if (dbg_we) begin
        if (dbg_q.size() == 0) check("dbg_unexpected", 128'(1), 128'(0));
        else begin
          md = dbg_q.pop_front();
          check("dbg_cyc", 128'(cyc), 128'(md.cyc));
          check("dbg_data", 128'({dbg_addr, dbg_wdata}), md.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit got=%0d exp=finish", cyc);
    $fatal(1);
  end

  initial begin
    logic [127:0] v, v5, v7, vw, vr;
    logic [63:0]  d [9];
    logic [63:0]  dd;
    int t, t2, ew, p;
    bit found;

    // Reset values
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_state", 128'(state), 128'(0));
    check("rst_cam_out", cam_out, 128'(0));
    check("rst_flags_out", 128'(flags_out), 128'(0));
    check("rst_loads", 128'({cam_load, flags_load, dbg_we}), 128'(0));
    check("rst_full_drop", 128'({dbg_full, dbg_drop}), 128'(0));
    check("rst_timeout", 128'(timeout), 128'(0));
    check("rst_frame_count", 128'(frame_count), 128'(0));
    check("rst_frame_cycles", 128'(frame_cycles), 128'(0));
    check("rst_dbg_addr", 128'({dbg_addr, dbg_wdata}), 128'(0));

    // IDLE pass-through
    tick();
    v = rnd128(); v[127:112] = 16'h0010;
    push_exp_cam(cyc + 1, v);
    pulse_cam(v);
    @(negedge clk);
    check("idle_cam_x", 128'(cam_out[127:112]), 128'(16'h0010));
    check("idle_state", 128'(state), 128'(0));
    push_exp_flg(cyc + 1, 4'b1010);
    pulse_flags(4'b1010);
    dd = {$urandom, $urandom};
    push_exp_dbg(cyc + 2, 18'h3ABCD, dd);
    pulse_dbg(18'h3ABCD, dd);
    repeat (3) tick();

    // Enter RUN
    enable = 1'b1;
    tick();
    @(negedge clk);
    check("run_state", 128'(state), 128'(1));

    // Last shadow value wins; single commit after frame_done
    v5 = rnd128(); v5[127:112] = 16'd5;
    v7 = rnd128(); v7[127:112] = 16'd7;
    pulse_cam(v5);
    pulse_cam(v7);
    pulse_flags(4'b0101);
    tick();
    t = cyc;
    push_exp_cam(t + 1, v7);
    push_exp_flg(t + 1, 4'b0101);
    pulse_fd();
    @(negedge clk);
    check("commit_state", 128'(state), 128'(2));
    check("frame_count_1", 128'(frame_count), 128'(1));
    check("commit_cam_x", 128'(cam_out[127:112]), 128'(16'd7));

    // Drain of a snapshot; a later push waits for the next frame
    tick();
    for (int i = 0; i < 3; i++) begin
      d[i] = {$urandom, $urandom};
      pulse_dbg(18'(i + 1), d[i]);
    end
    tick();
    t = cyc;
    for (int i = 0; i < 3; i++) push_exp_dbg(t + 2 + i, 18'(i + 1), d[i]);
    pulse_fd();
    tick();
    dd = {$urandom, $urandom};
    pulse_dbg(18'd4, dd);
    repeat (6) tick();
    t2 = cyc;
    push_exp_dbg(t2 + 2, 18'd4, dd);
    pulse_fd();
    repeat (4) tick();
    @(negedge clk);
    check("frame_count_3", 128'(frame_count), 128'(exp_fc));

    // Overflow: 9 pushes into an 8-deep FIFO
    for (int i = 0; i < 9; i++) begin
      d[i] = {$urandom, $urandom};
      pulse_dbg(18'(i + 16), d[i]);
    end
    @(negedge clk);
    check("ovf_full", 128'(dbg_full), 128'(1));
    check("ovf_drop", 128'(dbg_drop), 128'(1));
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    @(negedge clk);
    check("clr_drop", 128'(dbg_drop), 128'(0));
    check("clr_full_kept", 128'(dbg_full), 128'(1));

    // Drain 8, with a frame_done mid-drain forcing a second COMMIT
    t = cyc;
    for (int i = 0; i < 8; i++) push_exp_dbg(t + 2 + i, 18'(i + 16), d[i]);
    pulse_fd();
    repeat (3) tick();
    @(negedge clk);
    check("drain_state", 128'(state), 128'(3));
    pulse_fd();
    repeat (5) tick();
    @(negedge clk);
    check("redo_commit_state", 128'(cyc - t), 128'(10));
    check("redo_commit", 128'(state), 128'(2));
    check("frame_count_5", 128'(frame_count), 128'(exp_fc));

    // Watchdog: forced commit, frame_count untouched
    repeat (2) tick();
    vw = rnd128();
    ew = last_fd + TO + 1;
    push_exp_cam(ew, vw);
    pulse_cam(vw);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (timeout) found = 1'b1;
    end
    check("wd_seen", 128'(found), 128'(1));
    check("wd_cyc", 128'(cyc), 128'(ew));
    check("wd_state", 128'(state), 128'(2));
    check("wd_frame_count", 128'(frame_count), 128'(exp_fc));
    tick();
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    @(negedge clk);
    check("wd_clr", 128'(timeout), 128'(0));

    // Frame period: frame_done pulses 100 cycles apart
    p = cyc;
    pulse_fd();
    repeat (99) tick();
    check("fd_spacing", 128'(cyc - p), 128'(100));
    pulse_fd();
    @(negedge clk);
`ifdef VOXEL_SEQ_PERF_EN
    check("frame_cycles", 128'(frame_cycles), 128'(100));
`else
    check("frame_cycles", 128'(frame_cycles), 128'(0));
`endif
    check("frame_count_7", 128'(frame_count), 128'(exp_fc));

    // Back to IDLE; frame_done there is not counted
    enable = 1'b0;
    tick();
    @(negedge clk);
    check("idle_again", 128'(state), 128'(0));
    pulse_fd();
    tick();
    @(negedge clk);
    check("idle_fd_uncounted", 128'(frame_count), 128'(exp_fc));

    // Reset mid-drain discards remaining entries and pending updates
    enable = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      d[i] = {$urandom, $urandom};
      pulse_dbg(18'(i + 40), d[i]);
    end
    t = cyc;
    push_exp_dbg(t + 2, 18'd40, d[0]);
    pulse_fd();
    tick();
    vr = rnd128();
    pulse_cam(vr);
    rst_n = 1'b0;
    enable = 1'b0;
    exp_fc = 0;
    @(negedge clk);
    check("rst_mid_we", 128'(dbg_we), 128'(0));
    check("rst_mid_state", 128'(state), 128'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    check("post_rst_count", 128'(frame_count), 128'(0));
    check("cam_q_empty", 128'(cam_q.size()), 128'(0));
    check("flg_q_empty", 128'(flg_q.size()), 128'(0));
    check("dbg_q_empty", 128'(dbg_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
